uart_rx_deframer: RTL and testbench
===================================

// Module: uart_rx_deframer
// PURPOSE
// - UART 8-bit receiver: consumes the serial tx line from the UART transmitter and rebuilds bytes.
// - Sync input, mid-bit sampling, start/stop checks, valid/ready byte handoff with overrun flag.
// - Sits directly downstream of the transmitter on the same clk domain (loopback or external pin).
// PARAMETERS
// - CLK_FREQ  12000000  system clock, Hz
// - BAUD      9600      line rate, bit/s
// - LIM       CLK_FREQ/BAUD (1250)  clocks per bit, derived; HALF = LIM/2 (625)
// PORTS
// - clk         in   1  system clock, all logic on posedge
// - rst         in   1  synchronous, active-high reset
// - rx          in   1  serial line, idle high, async to bit timing
// - rx_data     out  8  received byte, LSB first on the line
// - rx_valid    out  1  byte available; held until accepted
// - rx_ready    in   1  consumer accepts when rx_valid && rx_ready at a clk edge
// - frame_err   out  1  1-cycle pulse: stop bit sampled 0
// - parity_err  out  1  1-cycle pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN)
// - overrun     out  1  1-cycle pulse: byte completed while previous still pending
// - busy        out  1  high in every state except IDLE
// BEHAVIOUR
// - Reset (any cycle, incl. mid-frame): state IDLE, bit counter, clock counter, shift reg cleared;
//   rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0; 2-FF sync regs = 1.
// - rx passes 2-FF synchronizer -> rx_s; previous rx_s kept for edge detect.
// - Clock counter width $clog2(LIM); counts 0..LIM-1, reset to 0 on every state change.
// - IDLE: armed only after rx_s==1 seen; armed && falling edge of rx_s -> START, cnt=0.
// - START: at cnt==HALF-1 sample rx_s; 0 -> DATA (bit_idx=0, cnt=0); 1 -> glitch, IDLE, no flags.
// - DATA: at cnt==LIM-1 shift rx_s into bit bit_idx (LSB first); after bit 7 -> STOP (or PARITY).
// - STOP: at cnt==LIM-1 (stop mid-bit) sample rx_s, go IDLE same edge:
//   1 -> byte complete; 0 -> frame_err pulse next cycle, byte discarded, IDLE re-arms only on rx_s==1.
// - Byte complete: if !rx_valid or (rx_valid && rx_ready this cycle) -> rx_data<=shift, rx_valid<=1
//   in cycle after the stop sample edge; else overrun pulse, new byte dropped, old rx_data kept.
// - rx_valid falls the cycle after rx_valid && rx_ready unless a new byte loads that same edge.
// - rx_data stable whenever rx_valid=1.
// - Latency: rx_valid rises 2 (sync) + HALF + 9*LIM + 1 clocks after rx falling edge (8N1).
// - Going IDLE at stop mid-bit lets back-to-back frames (no idle gap) be captured.
// CONFIGURATION
// - UART_RX_PARITY_EN defined: PARITY state between DATA and STOP; at cnt==LIM-1 sample even-parity
//   bit; mismatch -> parity_err 1-cycle pulse at stop-sample time, byte discarded (no rx_valid);
//   frame_err takes precedence if stop also 0 (only frame_err pulses).
// - Not defined: 8N1 only, no PARITY state, parity_err constant 0.
// TESTING (CLK_FREQ=12e6, BAUD=9600, LIM=1250)
// - 8N1 0x53, rx_ready=1 -> rx_valid 1 cycle, rx_data=0x53, frame_err/overrun=0, busy back to 0.
// - rx low 300 clocks then high -> no rx_valid, no flags, busy high <=627 clocks then 0.
// - 0xA5 with stop bit 0, then line high, then 0x3C -> frame_err 1 pulse, then rx_data=0x3C valid.
// - rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_valid held, rx_data=0x11, overrun pulse once.
// - rst=1 for 1 clock during data bit 4, then 0x6E -> all outputs 0 after reset, then rx_data=0x6E.
// - UART_RX_PARITY_EN: 0x70 parity 1 -> valid 0x70; 0x70 parity 0 -> parity_err pulse, no valid.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer -- 8-bit UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined).
// Synchronises the serial line, detects the start edge, samples every bit at its middle,
// checks the stop bit (and even parity when enabled), and hands each byte to the consumer
// through a valid/ready handshake.
//
// Build option:
//   UART_RX_PARITY_EN  defined   -> a PARITY state sits between DATA and STOP; an even-parity
//                                   mismatch discards the byte and pulses parity_err.
//                      undefined -> 8N1 only; parity_err is tied to 0.
//
// Ports:
//   clk         in   1  system clock, all logic on posedge
//   rst         in   1  synchronous, active-high reset
//   rx          in   1  serial line, idle high, asynchronous to bit timing
//   rx_data     out  8  received byte (LSB first on the line), stable while rx_valid=1
//   rx_valid    out  1  byte available, held until accepted
//   rx_ready    in   1  consumer accepts when rx_valid && rx_ready at a clk edge
//   frame_err   out  1  1-cycle pulse: stop bit sampled 0
//   parity_err  out  1  1-cycle pulse: parity mismatch
//   overrun     out  1  1-cycle pulse: byte completed while the previous one was still pending
//   busy        out  1  high in every state except IDLE
module uart_rx_deframer #(
    parameter int unsigned CLK_FREQ = 12000000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);
    localparam int unsigned LIM   = CLK_FREQ / BAUD;
    localparam int unsigned HALF  = LIM / 2;
    localparam int unsigned CNT_W = $clog2(LIM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIM - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state, state_next;
    logic             rx_meta, rx_s, rx_prev;
    logic             armed;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       shift, shift_next;
    logic             stop_sample;
    logic             parity_bad;

    // Two-flop synchroniser plus one extra stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt + CNT_W'(1);
        bit_next    = bit_idx;
        shift_next  = shift;
        stop_sample = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (armed && rx_prev && !rx_s)
                    state_next = S_START;
            end
            S_START: begin
                // Half a bit in: a line that is high again was only a glitch.
                if (cnt == CNT_MID) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next            = '0;
                    shift_next[bit_idx] = rx_s;
                    bit_next            = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
            S_PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                // Returning to IDLE at mid-stop lets a back-to-back start edge be caught.
                if (cnt == CNT_LAST) begin
                    cnt_next    = '0;
                    stop_sample = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk) begin
        if (rst)
            par_bit <= 1'b0;
        else if (state == S_PARITY && cnt == CNT_LAST)
            par_bit <= rx_s;
    end

    assign parity_bad = (^shift) != par_bit;
`else
    assign parity_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            armed   <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shift   <= shift_next;
            // Entering IDLE after a low stop bit leaves the receiver disarmed until the
            // line has been seen high again.
            if (state != S_IDLE && state_next == S_IDLE)
                armed <= rx_s;
            else if (state == S_IDLE)
                armed <= armed | rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (stop_sample) begin
                if (!rx_s) begin
                    frame_err <= 1'b1;
                end else if (!parity_bad) begin
                    if (!rx_valid || rx_ready) begin
                        rx_data  <= shift;
                        rx_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)
            parity_err <= 1'b0;
        else
            parity_err <= stop_sample && rx_s && parity_bad;
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer -- scoreboard bench for uart_rx_deframer.
// Frames are driven bit by bit on rx; before each frame a reference model decides from the
// frame contents and the consumer's readiness which event (byte, frame error, parity error,
// overrun) the receiver must report, and queues it. A monitor pops and compares whenever the
// DUT raises an event. Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx_deframer;
    localparam int unsigned CLK_FREQ = 960000;
    localparam int unsigned BAUD     = 9600;
    localparam int unsigned LIM      = CLK_FREQ / BAUD;
    localparam int unsigned HALF     = LIM / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // Start edge to rx_valid: 2 sync + 1 edge detect + half bit + data/parity/stop-middle bits.
    localparam int unsigned LAT = 3 + HALF + (PAR_EN ? 10 : 9) * LIM;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;
    int unsigned fall_cyc = 0;

    logic [7:0] data_q[$];
    int         frame_q[$];
    int         parity_q[$];
    int         ovr_q[$];
    bit         hold = 1'b0;
    bit         pending = 1'b0;

    uart_rx_deframer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return 1'($countones(d) % 2);
    endfunction

    // Reference model: what the receiver must report for one frame.
    task automatic expect_frame(input logic [7:0] d, input logic stop_b, input logic par_ok);
        if (!stop_b)
            frame_q.push_back(1);
        else if (PAR_EN && !par_ok)
            parity_q.push_back(1);
        else if (hold && pending)
            ovr_q.push_back(1);
        else begin
            data_q.push_back(d);
            if (hold)
                pending = 1'b1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (LIM) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_ok);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(d[i]);
        if (PAR_EN)
            drive_bit(par_ok ? even_par(d) : ~even_par(d));
        drive_bit(stop_b);
        rx = 1'b1;
    endtask

    task automatic idle(input int unsigned n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // rx_ready changes just after a posedge so the monitor never races it.
    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 rx_ready = r;
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rx_valid"},   32'(rx_valid),   0);
        check({tag, "_rx_data"},    32'(rx_data),    0);
        check({tag, "_frame_err"},  32'(frame_err),  0);
        check({tag, "_parity_err"}, 32'(parity_err), 0);
        check({tag, "_overrun"},    32'(overrun),    0);
        check({tag, "_busy"},       32'(busy),       0);
    endtask

    // Monitor / scoreboard
    logic       prev_valid = 1'b0;
    logic       prev_hs = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_valid && !prev_hs && rx_valid)
                check("rx_data_stable", 32'(rx_data), 32'(prev_data));
            if (rx_valid && !prev_valid)
                check("valid_latency", cyc - fall_cyc, LAT);
            if (rx_valid && rx_ready) begin
                check("byte_expected", 32'(data_q.size() != 0), 1);
                if (data_q.size() != 0)
                    check("rx_data", 32'(rx_data), 32'(data_q.pop_front()));
            end
            if (frame_err) begin
                check("frame_err_expected", 32'(frame_q.size() != 0), 1);
                if (frame_q.size() != 0)
                    void'(frame_q.pop_front());
            end
            if (parity_err) begin
                check("parity_err_expected", 32'(parity_q.size() != 0), 1);
                if (parity_q.size() != 0)
                    void'(parity_q.pop_front());
            end
            if (overrun) begin
                check("overrun_expected", 32'(ovr_q.size() != 0), 1);
                if (ovr_q.size() != 0)
                    void'(ovr_q.pop_front());
            end
        end
        prev_valid = rx_valid;
        prev_hs    = rx_valid && rx_ready;
        prev_data  = rx_data;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned busy_cnt;
        logic [7:0]  d;
        logic        stop_b, par_ok;

        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        idle(LIM);

        // Plain 8N1 byte with the consumer ready.
        expect_frame(8'h53, 1'b1, 1'b1);
        send_frame(8'h53, 1'b1, 1'b1);
        check("busy_after_53", 32'(busy), 0);
        idle(LIM);

        // Short low glitch: start rejected at mid-bit, no events.
        busy_cnt = 0;
        rx = 1'b0;
        for (int i = 0; i < 3 * LIM; i++) begin
            if (i == 24)
                rx = 1'b1;
            @(negedge clk);
            if (busy)
                busy_cnt++;
        end
        check("glitch_busy_len_ok", 32'(busy_cnt >= HALF - 2 && busy_cnt <= HALF + 2), 1);
        check("glitch_busy_end", 32'(busy), 0);

        // Bad stop bit, then a good byte after the line recovers.
        expect_frame(8'hA5, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(LIM);
        expect_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(LIM);

        // Consumer stalled, two back-to-back frames: second one overruns.
        set_ready(1'b0);
        hold = 1'b1;
        expect_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h11, 1'b1, 1'b1);
        expect_frame(8'h22, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        idle(LIM);
        check("held_valid", 32'(rx_valid), 1);
        check("held_data", 32'(rx_data), 32'h11);
        set_ready(1'b1);
        hold = 1'b0;
        pending = 1'b0;
        idle(LIM);

        // Pending byte and a partial frame wiped by a one-cycle reset during data bit 4.
        set_ready(1'b0);
        send_frame(8'h5A, 1'b1, 1'b1);
        idle(4);
        check("pre_reset_valid", 32'(rx_valid), 1);
        check("pre_reset_data", 32'(rx_data), 32'h5A);
        d = 8'hB7;
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++)
            drive_bit(d[i]);
        rx = d[4];
        repeat (HALF) @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero_outputs("midframe_reset");
        set_ready(1'b1);
        idle(LIM);
        expect_frame(8'h6E, 1'b1, 1'b1);
        send_frame(8'h6E, 1'b1, 1'b1);
        idle(LIM);

        // Even parity: correct bit accepted, wrong bit rejected.
        if (PAR_EN) begin
            expect_frame(8'h70, 1'b1, 1'b1);
            send_frame(8'h70, 1'b1, 1'b1);
            idle(LIM);
            expect_frame(8'h70, 1'b1, 1'b0);
            send_frame(8'h70, 1'b1, 1'b0);
            idle(LIM);
        end

        // Randomised frames with occasional framing/parity errors and random gaps.
        for (int n = 0; n < 12; n++) begin
            d      = 8'($urandom);
            stop_b = ($urandom_range(0, 5) != 0);
            par_ok = PAR_EN ? ($urandom_range(0, 5) != 0) : 1'b1;
            expect_frame(d, stop_b, par_ok);
            send_frame(d, stop_b, par_ok);
            idle(stop_b ? $urandom_range(0, LIM) : $urandom_range(4, LIM));
        end

        idle(2 * LIM);
        check("bytes_drained", data_q.size(), 0);
        check("frame_err_drained", frame_q.size(), 0);
        check("parity_err_drained", parity_q.size(), 0);
        check("overrun_drained", ovr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
